counter_threshold_monitor: RTL and testbench
============================================

# counter_threshold_monitor

Downstream consumer of the counter array's `cnt` outputs. Scans the eight 5-bit counters round-robin, one per clock. Keeps a per-counter alarm flag with hysteresis: sets at or above a high-water mark, clears at or below a low-water mark. Each alarm transition is reported as a single event on a valid/ready output port for the interrupt/status logic.

## Interface
Parameters:
- `N`, 8: number of counters scanned (matches counter array depth).
- `W`, 5: counter width.
- `HI`, 24: alarm set threshold (inclusive).
- `LO`, 8: alarm clear threshold (inclusive). Must satisfy `LO < HI < 2**W`; elaboration error otherwise.

Ports:
- Clock and reset: one clock `clk`; reset `rst`, asynchronous, active-high.
- `clk`  input  1  clock.
- `rst`  input  1  asynchronous active-high reset.
- `en`  input  1  scan enable; when 0, pointer and alarms hold.
- `cnt`  input  W x [0:N-1]  unpacked counter array from the counter array block.
- `alarm`  output  N  per-counter alarm flags (bit i ↔ `cnt[i]`).
- `any_alarm`  output  1  OR of `alarm`, registered.
- `evt_valid`  output  1  event pending.
- `evt_idx`  output  clog2(N)  counter index of pending event.
- `evt_set`  output  1  1 = alarm raised, 0 = alarm cleared.
- `evt_ready`  input  1  consumer accepts event.
- `scan_ptr`  output  clog2(N)  current scan index (debug/verification).

## Operation
- Registers: `scan_ptr`, `alarm[N-1:0]`, `any_alarm`, one-entry event register (`evt_valid`, `evt_idx`, `evt_set`).
- Reset values: `scan_ptr` = 0, `alarm` = 0, `any_alarm` = 0, `evt_valid` = 0, `evt_idx` = 0, `evt_set` = 0.
- Each cycle with `en`=1, examine `i = scan_ptr`, `c = cnt[i]` (unsigned):
  - raise: `alarm[i]`=0 and `c >= HI`.
  - clear: `alarm[i]`=1 and `c <= LO`.
  - otherwise no transition; LO < c < HI never changes state (hysteresis band).
- Slot free = `!evt_valid || evt_ready`.
- Transition and slot free:
  - toggle `alarm[i]`.
  - load event: `evt_valid`=1, `evt_idx`=i, `evt_set`=new alarm value.
  - advance pointer.
- Transition and slot busy (stall):
  - `alarm`, `scan_ptr` and the event register hold.
  - Same counter is re-evaluated next cycle using its current `cnt` value. If it has re-entered the band, no event is generated.
- No transition: advance pointer.
- Event handshake:
  - Event is consumed on any cycle with `evt_valid && evt_ready`.
  - If no new event loads that cycle, `evt_valid` → 0.
  - Accept and load in the same cycle is allowed: back-to-back events with no bubble.
  - While `evt_valid`=1 and `evt_ready`=0, `evt_idx`/`evt_set` are stable.
- Pointer advance: `scan_ptr` = `(scan_ptr == N-1) ? 0 : scan_ptr+1` (wrap 7→0).
- `en`=0:
  - no evaluation; pointer and alarms hold.
  - Pending event still drains via `evt_ready`.
- `any_alarm` is registered from the next-state `alarm` vector, so it updates in the same cycle as `alarm`.
- Reset asserted mid-operation (including during a stall): all registers go to their reset values immediately. A pending event is discarded.

## Timing
- Event latency: transition detected at scan cycle T → `alarm[i]` and `evt_valid` high after clock edge T+1.
- Scan period: N cycles per full sweep with no stalls. A counter crossing a threshold is reported within N cycles plus any accumulated stall cycles.
- Stall cycles: one per cycle that `evt_valid && !evt_ready` blocks a transition.
- Throughput: one event per cycle maximum, with `evt_ready` held high.
- `cnt` is treated as synchronous to `clk`; no input registering.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs 0 immediately. Deassert with all `cnt`=0, `en`=1 → `scan_ptr` counts 0..7,0 and no `evt_valid` for 16 cycles.
- Raise and clear: `cnt[3]`=24, `evt_ready`=1 → one event {`idx`=3, `set`=1}, `alarm`=8'h08, `any_alarm`=1. Then `cnt[3]`=9 → no event for 2 sweeps. Then `cnt[3]`=8 → event {3, 0}, `alarm`=0.
- Back-to-back: `cnt[0]`=`cnt[1]`=31 at `scan_ptr`=0, `evt_ready`=1 → `evt_valid` high 2 consecutive cycles, idx 0 then 1, `alarm`=8'h03.
- Backpressure: `evt_ready`=0, `cnt[5]`=`cnt[6]`=30 → event {5, 1} holds stable. `scan_ptr` stalls at 6 while `evt_ready`=0. Raise `evt_ready` → event {6, 1} loads the next cycle and the scan resumes at 7.
- Stall re-evaluation: while stalled at index 6, drop `cnt[6]` to 20 before `evt_ready` rises → no event for 6, `alarm[6]` stays 0, pointer advances.
- Enable and wrap: `en`=0 with `cnt[7]`=25 → pointer and `alarm` frozen. `en`=1 → event {7, 1} when the pointer reaches 7, after which `scan_ptr` wraps to 0.

Source files
------------

// File: rtl/counter_threshold_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : counter_threshold_monitor
//  Description : Scans N counters round-robin, one per clock, and keeps a
//                per-counter alarm flag with hysteresis.
//                - An alarm sets when its counter reaches HI.
//                - An alarm clears when its counter falls to LO.
//                Every alarm transition is reported once on a one-entry
//                valid/ready event port.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_threshold_monitor #(
  parameter int N  = 8,
  parameter int W  = 5,
  parameter int HI = 24,
  parameter int LO = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  cnt [0:N-1],
  output logic [N-1:0]  alarm,
  output logic          any_alarm,
  output logic          evt_valid,
  output logic [IW-1:0] evt_idx,
  output logic          evt_set,
  input  logic          evt_ready,
  output logic [IW-1:0] scan_ptr
);

  // Threshold set must leave a non-empty hysteresis band inside the counter range.
  generate
    if (!((LO < HI) && (HI < (2 ** W)))) begin : g_bad_thresholds
      $error("counter_threshold_monitor: need LO < HI < 2**W");
    end
  endgenerate

  localparam logic [W-1:0]  C_HI   = HI[W-1:0];
  localparam logic [W-1:0]  C_LO   = LO[W-1:0];
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  logic [W-1:0]  w_cur_cnt;
  logic          w_cur_alarm;
  logic          w_raise;
  logic          w_clear;
  logic          w_trans;
  logic          w_slot_free;
  logic          w_load;
  logic          w_advance;
  logic [N-1:0]  w_alarm_nxt;
  logic [IW-1:0] w_ptr_nxt;

  // Evaluate the counter under the pointer and decide toggle, event load and advance.
  always_comb begin
    w_cur_cnt   = cnt[scan_ptr];
    w_cur_alarm = alarm[scan_ptr];
    w_raise     = !w_cur_alarm && (w_cur_cnt >= C_HI);
    w_clear     =  w_cur_alarm && (w_cur_cnt <= C_LO);
    w_trans     = en && (w_raise || w_clear);
    w_slot_free = !evt_valid || evt_ready;
    w_load      = w_trans && w_slot_free;
    // A transition that cannot be posted parks the pointer so the same
    // counter is looked at again with its fresh value next cycle.
    w_advance   = en && (!w_trans || w_slot_free);

    w_alarm_nxt = alarm;
    if (w_load) begin
      w_alarm_nxt[scan_ptr] = !w_cur_alarm;
    end

    w_ptr_nxt = scan_ptr;
    if (w_advance) begin
      w_ptr_nxt = (scan_ptr == C_LAST) ? '0 : scan_ptr + IW'(1);
    end
  end

  // Scan pointer, alarm vector and its registered OR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr  <= '0;
      alarm     <= '0;
      any_alarm <= 1'b0;
    end else begin
      scan_ptr  <= w_ptr_nxt;
      alarm     <= w_alarm_nxt;
      any_alarm <= |w_alarm_nxt;
    end
  end

  // One-entry event register; a load in the same cycle as an accept wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_set   <= 1'b0;
    end else if (w_load) begin
      evt_valid <= 1'b1;
      evt_idx   <= scan_ptr;
      evt_set   <= !w_cur_alarm;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_threshold_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_threshold_monitor
//  Description : Self-checking bench for counter_threshold_monitor: directed
//                scenarios followed by randomized traffic, all checked
//                against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_threshold_monitor;

  localparam int N  = 8;
  localparam int W  = 5;
  localparam int HI = 24;
  localparam int LO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] cnt [0:N-1];
  logic [N-1:0] alarm;
  logic         any_alarm;
  logic         evt_valid;
  logic [2:0]   evt_idx;
  logic         evt_set;
  logic         evt_ready;
  logic [2:0]   scan_ptr;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int m_ptr;
  bit m_alarm [N];
  bit m_valid;
  int m_idx;
  bit m_set;

  always #5 clk = ~clk;

  counter_threshold_monitor #(.N(N), .W(W), .HI(HI), .LO(LO)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt       (cnt),
    .alarm     (alarm),
    .any_alarm (any_alarm),
    .evt_valid (evt_valid),
    .evt_idx   (evt_idx),
    .evt_set   (evt_set),
    .evt_ready (evt_ready),
    .scan_ptr  (scan_ptr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_alarm_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_alarm[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_alarm[i] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_set   = 1'b0;
  endtask

  // Predict the state after the coming edge from the current inputs.
  task automatic model_step();
    int  c;
    bit  want;
    bit  change;
    bit  free;
    c      = int'(cnt[m_ptr]);
    // Desired flag given the hysteresis rule: stays set until c <= LO,
    // stays clear until c >= HI.
    want   = m_alarm[m_ptr] ? (c > LO) : (c >= HI);
    change = en && (want != m_alarm[m_ptr]);
    free   = !m_valid || evt_ready;
    if (change && free) begin
      m_alarm[m_ptr] = want;
      m_valid = 1'b1;
      m_idx   = m_ptr;
      m_set   = want;
      m_ptr   = (m_ptr + 1) % N;
    end else begin
      if (m_valid && evt_ready) m_valid = 1'b0;
      if (en && !change) m_ptr = (m_ptr + 1) % N;
    end
  endtask

  task automatic compare_all();
    check("alarm", 32'(alarm), 32'(model_alarm_vec()));
    check("any_alarm", 32'(any_alarm), 32'(model_alarm_vec() != 0));
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    check("scan_ptr", 32'(scan_ptr), 32'(m_ptr));
    if (m_valid) begin
      check("evt_idx", 32'(evt_idx), 32'(m_idx));
      check("evt_set", 32'(evt_set), 32'(m_set));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_all_cnt();
    for (int i = 0; i < N; i++) cnt[i] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alarm"}, 32'(alarm), 32'h0);
    check({tag, "_any"}, 32'(any_alarm), 32'h0);
    check({tag, "_valid"}, 32'(evt_valid), 32'h0);
    check({tag, "_idx"}, 32'(evt_idx), 32'h0);
    check({tag, "_set"}, 32'(evt_set), 32'h0);
    check({tag, "_ptr"}, 32'(scan_ptr), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    evt_ready = 1'b0;
    clear_all_cnt();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Idle sweep: pointer walks 0..7,0 with no events.
    en = 1'b1;
    ticks(16);
    check("idle_ptr", 32'(scan_ptr), 32'd0);

    // Raise then hysteresis band then clear on counter 3.
    evt_ready = 1'b1;
    cnt[3] = 5'd24;
    ticks(9);
    check("raise_alarm", 32'(alarm), 32'h08);
    check("raise_any", 32'(any_alarm), 32'd1);
    cnt[3] = 5'd9;
    ticks(16);
    check("band_alarm", 32'(alarm), 32'h08);
    cnt[3] = 5'd8;
    ticks(9);
    check("clear_alarm", 32'(alarm), 32'h00);

    // Back-to-back events on counters 0 and 1.
    for (int k = 0; k < N && m_ptr != 0; k++) tick();
    cnt[0] = 5'd31;
    cnt[1] = 5'd31;
    tick();
    check("b2b_v0", 32'(evt_valid), 32'd1);
    check("b2b_i0", 32'(evt_idx), 32'd0);
    tick();
    check("b2b_v1", 32'(evt_valid), 32'd1);
    check("b2b_i1", 32'(evt_idx), 32'd1);
    check("b2b_alarm", 32'(alarm), 32'h03);
    clear_all_cnt();
    ticks(10);

    // Backpressure: event for 5 held, scan stalls at 6.
    evt_ready = 1'b0;
    cnt[5] = 5'd30;
    cnt[6] = 5'd30;
    ticks(12);
    check("bp_ptr", 32'(scan_ptr), 32'd6);
    check("bp_idx", 32'(evt_idx), 32'd5);
    check("bp_set", 32'(evt_set), 32'd1);
    evt_ready = 1'b1;
    tick();
    check("bp_idx6", 32'(evt_idx), 32'd6);
    check("bp_ptr7", 32'(scan_ptr), 32'd7);
    clear_all_cnt();
    ticks(12);

    // Stall re-evaluation: counter 6 falls back into the band while stalled.
    evt_ready = 1'b0;
    cnt[5] = 5'd30;
    cnt[6] = 5'd30;
    ticks(12);
    check("re_ptr", 32'(scan_ptr), 32'd6);
    cnt[6] = 5'd20;
    tick();
    check("re_ptr_adv", 32'(scan_ptr), 32'd7);
    evt_ready = 1'b1;
    ticks(3);
    check("re_alarm6", 32'(alarm[6]), 32'd0);
    clear_all_cnt();
    ticks(12);

    // Enable low freezes scan; re-enable reports 7 then wraps.
    en = 1'b0;
    cnt[7] = 5'd25;
    ticks(5);
    en = 1'b1;
    for (int k = 0; k < N && !(m_valid && m_idx == 7); k++) tick();
    check("wrap_idx", 32'(evt_idx), 32'd7);
    check("wrap_ptr", 32'(scan_ptr), 32'd0);
    clear_all_cnt();
    ticks(10);

    // Asynchronous reset during a stall discards everything.
    evt_ready = 1'b0;
    cnt[2] = 5'd31;
    cnt[4] = 5'd31;
    ticks(12);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1;
    rst = 1'b0;
    clear_all_cnt();
    ticks(4);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) < 2) cnt[i] = W'($urandom_range(0, 31));
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
